serial_tx_ctrl: RTL and testbench

SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

---
 rtl/serial_tx_pkg.sv | 13 +
 rtl/piso_shift_reg.sv | 33 +++
 rtl/serial_tx_ctrl.sv | 114 +++++++++++
 tb/tb_serial_tx_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and default build constants for the serial transmit controller.
package serial_tx_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_GAP   = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } tx_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with a per-load bit-order select.
module piso_shift_reg
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             load,
   input  logic             shift_en,
   input  logic             msb_first,
   input  logic [WIDTH-1:0] din,
   output logic             so
);

   logic [WIDTH-1:0] data_p0;
   logic             dir_p0;

   // Stage p0: holds the captured word and its bit order.
   always_ff @(posedge clk) begin
      if (load) begin
         data_p0 <= din;
         dir_p0  <= msb_first;
      end else if (shift_en) begin
         if (dir_p0)
            data_p0 <= {data_p0[WIDTH-2:0], 1'b0};
         else
            data_p0 <= {1'b0, data_p0[WIDTH-1:1]};
      end
   end

   assign so = dir_p0 ? data_p0[WIDTH-1] : data_p0[0];

endmodule

// File: rtl/serial_tx_ctrl.sv
// Serial transmit controller: accepts a parallel word, shifts it out one bit per
// cycle, then holds an idle gap before accepting the next word.
module serial_tx_ctrl
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int GAP   = DEFAULT_GAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din_data,
   input  logic             msb_first,
   input  logic             abort,
   output logic             din_ready,
   output logic             so,
   output logic             so_valid,
   output logic             busy,
   output logic             done
);

   localparam int BCW = $clog2(WIDTH);
   localparam int GCW = $clog2(GAP + 2);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP - 1);

   tx_state_t      state, state_nxt;
   logic [BCW-1:0] bitcnt, bitcnt_nxt;
   logic [GCW-1:0] gapcnt, gapcnt_nxt;
   logic           done_nxt;
   logic           load;
   logic           shift_en;
   logic           piso_so;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         bitcnt <= '0;
         gapcnt <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         bitcnt <= bitcnt_nxt;
         gapcnt <= gapcnt_nxt;
         done   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      bitcnt_nxt = bitcnt;
      gapcnt_nxt = gapcnt;
      done_nxt   = 1'b0;
      load       = 1'b0;
      shift_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            // Abort is meaningless here, so a simultaneous valid still wins.
            if (din_valid) begin
               load       = 1'b1;
               state_nxt  = ST_SHIFT;
               bitcnt_nxt = '0;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_nxt  = ST_IDLE;
               bitcnt_nxt = '0;
            end else begin
               shift_en = 1'b1;
               if (bitcnt == BIT_LAST) begin
                  bitcnt_nxt = '0;
                  gapcnt_nxt = '0;
                  done_nxt   = 1'b1;
                  state_nxt  = (GAP > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  bitcnt_nxt = bitcnt + BCW'(1);
               end
            end
         end
         ST_GAP: begin
            if (gapcnt == GAP_LAST) begin
               gapcnt_nxt = '0;
               state_nxt  = ST_IDLE;
            end else begin
               gapcnt_nxt = gapcnt + GCW'(1);
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            bitcnt_nxt = '0;
            gapcnt_nxt = '0;
         end
      endcase
   end

   piso_shift_reg #(
      .WIDTH(WIDTH)
   ) u_piso (
      .clk      (clk),
      .load     (load),
      .shift_en (shift_en),
      .msb_first(msb_first),
      .din      (din_data),
      .so       (piso_so)
   );

   // Outputs decode straight from state so an async reset clears them at once.
   assign din_ready = (state == ST_IDLE);
   assign so_valid  = (state == ST_SHIFT);
   assign so        = so_valid & piso_so;
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl: GAP=1 instance for most scenarios, GAP=0 instance for back-to-back.
module tb_serial_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din_valid = 1'b0;
   logic [7:0] din_data = '0;
   logic       msb_first = 1'b0;
   logic       abort = 1'b0;
   logic       din_ready, so, so_valid, busy, done;

   logic       din_valid1 = 1'b0;
   logic [7:0] din_data1 = '0;
   logic       msb_first1 = 1'b0;
   logic       abort1 = 1'b0;
   logic       din_ready1, so1, so_valid1, busy1, done1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_tx_ctrl #(.WIDTH(8), .GAP(1)) u0 (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din_data(din_data),
      .msb_first(msb_first), .abort(abort), .din_ready(din_ready),
      .so(so), .so_valid(so_valid), .busy(busy), .done(done)
   );

   serial_tx_ctrl #(.WIDTH(8), .GAP(0)) u1 (
      .clk(clk), .rst(rst), .din_valid(din_valid1), .din_data(din_data1),
      .msb_first(msb_first1), .abort(abort1), .din_ready(din_ready1),
      .so(so1), .so_valid(so_valid1), .busy(busy1), .done(done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input logic m, input int i);
      return m ? d[7-i] : d[i];
   endfunction

   // Sends one frame on u0 from IDLE and checks bits, done pulse and gap.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic m, input logic ab);
      din_valid = 1'b1;
      din_data  = d;
      msb_first = m;
      abort     = ab;
      chk({tag, "_rdy_pre"}, din_ready, 1);
      tick();
      din_valid = 1'b0;
      abort     = 1'b0;
      din_data  = ~d;
      msb_first = ~m;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_vld%0d", tag, i), so_valid, 1);
         chk($sformatf("%s_bit%0d", tag, i), so, exp_bit(d, m, i));
         chk($sformatf("%s_nodone%0d", tag, i), done, 0);
         tick();
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_gap_vld"}, so_valid, 0);
      chk({tag, "_gap_rdy"}, din_ready, 0);
      chk({tag, "_gap_busy"}, busy, 1);
      tick();
      chk({tag, "_done_end"}, done, 0);
      chk({tag, "_rdy_back"}, din_ready, 1);
      chk({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int sovc;

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_rdy", din_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_vld", so_valid, 0);
      chk("rst_so", so, 0);
      chk("rst_done", done, 0);
      chk("rst_rdy1", din_ready1, 1);
      #10 rst = 1'b0;
      tick();
      chk("post_rst_busy", busy, 0);

      // A5 MSB first, then 01 / 80 LSB first, then abort-in-IDLE accepted with 3C
      run_frame("a5", 8'hA5, 1'b1, 1'b0);
      run_frame("x01", 8'h01, 1'b0, 1'b0);
      run_frame("x80", 8'h80, 1'b0, 1'b0);

      // Held valid: F0 then 0F
      din_valid = 1'b1;
      din_data  = 8'hF0;
      msb_first = 1'b1;
      tick();
      din_data = 8'h0F;
      cnt  = 0;
      sovc = 0;
      while (!din_ready && cnt < 30) begin
         chk($sformatf("hold_busy%0d", cnt), busy, 1);
         if (so_valid) begin
            chk($sformatf("hold_f0bit%0d", sovc), so, exp_bit(8'hF0, 1'b1, sovc));
            sovc++;
         end
         tick();
         cnt++;
      end
      chk("hold_spacing", cnt + 1, 10);
      chk("hold_nbits", sovc, 8);
      chk("hold_idle_busy", busy, 0);
      tick();
      din_valid = 1'b0;
      chk("hold_busy2", busy, 1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("hold_0fbit%0d", i), so, exp_bit(8'h0F, 1'b1, i));
         tick();
      end
      chk("hold_done2", done, 1);
      tick();
      chk("hold_rdy2", din_ready, 1);

      // Abort during the 4th bit of FF
      din_valid = 1'b1;
      din_data  = 8'hFF;
      msb_first = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (3) tick();
      chk("ab_vld_b3", so_valid, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_vld_off", so_valid, 0);
      chk("ab_so_off", so, 0);
      chk("ab_rdy", din_ready, 1);
      chk("ab_nodone", done, 0);
      tick();
      chk("ab_nodone2", done, 0);
      chk("ab_busy", busy, 0);
      run_frame("x3c", 8'h3C, 1'b1, 1'b1);

      // Async reset during bit 5 of 5A
      din_valid = 1'b1;
      din_data  = 8'h5A;
      msb_first = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (4) tick();
      chk("ar_vld_b5", so_valid, 1);
      chk("ar_bit5", so, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_vld", so_valid, 0);
      chk("ar_so", so, 0);
      chk("ar_busy", busy, 0);
      chk("ar_rdy", din_ready, 1);
      chk("ar_done", done, 0);
      tick();
      #3 rst = 1'b0;
      tick();
      chk("ar_post_vld", so_valid, 0);
      chk("ar_post_done", done, 0);
      chk("ar_post_busy", busy, 0);
      run_frame("xc3", 8'hC3, 1'b1, 1'b0);

      // GAP=0 back-to-back AA then 55
      din_valid1 = 1'b1;
      din_data1  = 8'hAA;
      msb_first1 = 1'b1;
      tick();
      din_data1 = 8'h55;
      cnt  = 0;
      sovc = 0;
      while (!din_ready1 && cnt < 30) begin
         if (so_valid1) begin
            chk($sformatf("g0_aabit%0d", sovc), so1, exp_bit(8'hAA, 1'b1, sovc));
            sovc++;
         end
         tick();
         cnt++;
      end
      chk("g0_spacing", cnt + 1, 9);
      chk("g0_nbits", sovc, 8);
      chk("g0_done1", done1, 1);
      tick();
      din_valid1 = 1'b0;
      chk("g0_done1_end", done1, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("g0_55bit%0d", i), so1, exp_bit(8'h55, 1'b1, i));
         tick();
      end
      chk("g0_done2", done1, 1);
      chk("g0_busy_end", busy1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
